// File: rtl/fuel_keypad_entry.sv
// fuel_keypad_entry: 4x4 keypad scanner, frame debouncer and amount/fuel entry FSM feeding btl_htn.
// Define KEYPAD_MIN_AMOUNT_EN to reject confirmed amounts below MIN_AMOUNT.
module fuel_keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MIN_AMOUNT     = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        done,
  output logic [23:0] keyboard,
  output logic [2:0]  select,
  output logic        start,
  output logic [27:0] digits,
  output logic        err
);

`ifdef KEYPAD_MIN_AMOUNT_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);
  localparam logic [23:0]      MIN_VAL   = 24'(MIN_AMOUNT);

  typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_MULTI} frame_t;
  typedef enum logic [1:0] {ST_ENTRY, ST_CONVERT, ST_ARMED} state_t;

  // ---------------------------------------------------------------- scanner
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       col_idx_reg;
  logic             scan_tick;

  assign scan_tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      col_idx_reg <= 2'd0;
      col         <= 4'b1110;
    end else if (scan_tick) begin
      div_cnt_reg <= '0;
      col_idx_reg <= col_idx_reg + 2'd1;
      col         <= {col[2:0], col[3]};
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Rows come from the mechanical keypad, so they pass a two-flop synchronizer
  // before being sampled at the end of the column period.
  logic [3:0] row_s1_reg;
  logic [3:0] row_s2_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_reg <= 4'hF;
      row_s2_reg <= 4'hF;
    end else begin
      row_s1_reg <= row;
      row_s2_reg <= row_s1_reg;
    end
  end

  logic [3:0] low;
  logic [2:0] n_low;
  logic [1:0] row_idx;

  assign low = ~row_s2_reg;

  always_comb begin
    n_low   = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) row_idx = 2'(i);
    end
  end

  // ------------------------------------------------------ frame accumulator
  logic       frm_key_reg;
  logic       frm_multi_reg;
  logic [3:0] frm_code_reg;
  logic       frm_key_next;
  logic       frm_multi_next;
  logic [3:0] frm_code_next;
  logic       frame_done;
  frame_t     frame_res;

  always_comb begin
    frm_key_next   = frm_key_reg | (n_low == 3'd1);
    frm_multi_next = frm_multi_reg | (n_low > 3'd1) | (frm_key_reg & (n_low == 3'd1));
    frm_code_next  = (!frm_key_reg && (n_low == 3'd1)) ? {row_idx, col_idx_reg} : frm_code_reg;
    frame_done     = scan_tick && (col_idx_reg == 2'd3);
    if (frm_multi_next)    frame_res = FR_MULTI;
    else if (frm_key_next) frame_res = FR_KEY;
    else                   frame_res = FR_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frm_key_reg   <= 1'b0;
      frm_multi_reg <= 1'b0;
      frm_code_reg  <= 4'd0;
    end else if (scan_tick) begin
      if (col_idx_reg == 2'd3) begin
        frm_key_reg   <= 1'b0;
        frm_multi_reg <= 1'b0;
        frm_code_reg  <= 4'd0;
      end else begin
        frm_key_reg   <= frm_key_next;
        frm_multi_reg <= frm_multi_next;
        frm_code_reg  <= frm_code_next;
      end
    end
  end

  // -------------------------------------------------------------- debouncer
  frame_t          last_type_reg;
  logic [3:0]      last_code_reg;
  logic [DB_W-1:0] stab_cnt_reg;
  logic            released_reg;
  logic            key_evt_reg;
  logic [3:0]      key_code_reg;
  logic [DB_W-1:0] stab_inc;
  logic [DB_W-1:0] cnt_next;
  logic            same_frame;

  always_comb begin
    stab_inc   = (stab_cnt_reg == DB_TARGET) ? stab_cnt_reg : stab_cnt_reg + DB_W'(1);
    same_frame = (frame_res == last_type_reg) &&
                 ((frame_res != FR_KEY) || (frm_code_next == last_code_reg));
    cnt_next   = same_frame ? stab_inc : DB_W'(1);
  end

  // The released flag is what suppresses auto-repeat while a key stays down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_type_reg <= FR_NONE;
      last_code_reg <= 4'd0;
      stab_cnt_reg  <= '0;
      released_reg  <= 1'b1;
      key_evt_reg   <= 1'b0;
      key_code_reg  <= 4'd0;
    end else begin
      key_evt_reg <= 1'b0;
      if (frame_done) begin
        last_type_reg <= frame_res;
        last_code_reg <= frm_code_next;
        case (frame_res)
          FR_MULTI: stab_cnt_reg <= '0;
          FR_KEY: begin
            stab_cnt_reg <= cnt_next;
            if (released_reg && (cnt_next == DB_TARGET)) begin
              key_evt_reg  <= 1'b1;
              key_code_reg <= frm_code_next;
              released_reg <= 1'b0;
            end
          end
          default: begin
            stab_cnt_reg <= cnt_next;
            if (cnt_next == DB_TARGET) released_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------------- key decode
  logic [1:0] key_r;
  logic [1:0] key_c;
  logic       is_digit;
  logic [3:0] digit_val;
  logic       is_fsel;
  logic [2:0] fsel_val;
  logic       is_star;
  logic       is_hash;
  logic       is_bksp;

  assign key_r = key_code_reg[3:2];
  assign key_c = key_code_reg[1:0];

  always_comb begin
    is_digit  = 1'b0;
    digit_val = 4'd0;
    is_fsel   = 1'b0;
    fsel_val  = 3'd0;
    is_star   = 1'b0;
    is_hash   = 1'b0;
    is_bksp   = 1'b0;
    if (key_c == 2'd3) begin
      if (key_r == 2'd3) begin
        is_bksp = 1'b1;
      end else begin
        is_fsel  = 1'b1;
        fsel_val = {1'b0, key_r} + 3'd1;
      end
    end else if (key_r == 2'd3) begin
      case (key_c)
        2'd0:    is_star  = 1'b1;
        2'd1:    is_digit = 1'b1;
        default: is_hash  = 1'b1;
      endcase
    end else begin
      is_digit  = 1'b1;
      digit_val = ({2'd0, key_r} * 4'd3) + {2'd0, key_c} + 4'd1;
    end
  end

  // -------------------------------------------------------------- entry FSM
  state_t      state_reg;
  logic [2:0]  count_reg;
  logic [2:0]  conv_idx_reg;
  logic [23:0] acc_reg;
  logic [27:0] conv_sr_reg;
  logic [23:0] acc_next;
  logic        below_min;

  assign acc_next  = (acc_reg * 24'd10) + {20'd0, conv_sr_reg[27:24]};
  assign below_min = MIN_EN && (acc_next < MIN_VAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_ENTRY;
      count_reg    <= 3'd0;
      conv_idx_reg <= 3'd0;
      acc_reg      <= 24'd0;
      conv_sr_reg  <= 28'd0;
      keyboard     <= 24'd0;
      select       <= 3'd0;
      start        <= 1'b0;
      digits       <= 28'd0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_reg)
        ST_ENTRY: begin
          if (key_evt_reg) begin
            if (is_digit) begin
              if ((count_reg < 3'd7) && !((digit_val == 4'd0) && (count_reg == 3'd0))) begin
                digits    <= {digits[23:0], digit_val};
                count_reg <= count_reg + 3'd1;
              end
            end else if (is_bksp) begin
              if (count_reg != 3'd0) begin
                digits    <= {4'd0, digits[27:4]};
                count_reg <= count_reg - 3'd1;
              end
            end else if (is_star) begin
              digits    <= 28'd0;
              count_reg <= 3'd0;
              select    <= 3'd0;
            end else if (is_fsel) begin
              select <= fsel_val;
            end else if (is_hash) begin
              if ((select != 3'd0) && (count_reg != 3'd0)) begin
                state_reg    <= ST_CONVERT;
                conv_idx_reg <= 3'd0;
                acc_reg      <= 24'd0;
                conv_sr_reg  <= digits;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        // All 7 digit slots are walked MS first; unused leading slots are zero.
        ST_CONVERT: begin
          if (conv_idx_reg == 3'd6) begin
            keyboard <= acc_next;
            if (below_min) begin
              err       <= 1'b1;
              state_reg <= ST_ENTRY;
            end else begin
              start     <= 1'b1;
              state_reg <= ST_ARMED;
            end
          end else begin
            acc_reg      <= acc_next;
            conv_sr_reg  <= {conv_sr_reg[23:0], 4'd0};
            conv_idx_reg <= conv_idx_reg + 3'd1;
          end
        end
        ST_ARMED: begin
          if (done || (key_evt_reg && is_star)) begin
            start     <= 1'b0;
            keyboard  <= 24'd0;
            digits    <= 28'd0;
            count_reg <= 3'd0;
            select    <= 3'd0;
            state_reg <= ST_ENTRY;
          end
        end
        default: state_reg <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_fuel_keypad_entry.sv
// Scoreboard bench for fuel_keypad_entry: directed key sequences push expected digits,
// armed results, err pulses and releases; a negedge monitor pops and compares them.
module tb_fuel_keypad_entry;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int MIN_AMT  = 10000;
  localparam int FRAME    = 4 * SCAN_DIV;

  localparam int K1 = 0,  K2 = 1,  K3 = 2,  KA = 3;
  localparam int K4 = 4,  K5 = 5,  K6 = 6,  KB = 7;
  localparam int K7 = 8,  K8 = 9,  K9 = 10, KC = 11;
  localparam int KSTAR = 12, K0 = 13, KHASH = 14, KD = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        done = 1'b0;
  logic [23:0] keyboard;
  logic [2:0]  select;
  logic        start;
  logic [27:0] digits;
  logic        err;

  logic [15:0] pressed = 16'd0;
  int tests_run = 0;
  int fail_cnt  = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fuel_keypad_entry #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .MIN_AMOUNT(MIN_AMT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .done(done),
    .keyboard(keyboard),
    .select(select),
    .start(start),
    .digits(digits),
    .err(err)
  );

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  typedef struct {
    logic [23:0] kb;
    logic [2:0]  sel;
  } armed_t;

  logic [27:0] dig_q[$];
  armed_t      armed_q[$];
  int          err_q[$];
  int          rel_q[$];
  armed_t      mon_a;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ----------------------------------------------------------------- monitor
  logic [27:0] prev_digits = 28'd0;
  logic        prev_start = 1'b0;
  logic        prev_err = 1'b0;
  int          last_evt_cyc = -100;
  int          last_done_cyc = -100;

  always @(negedge clk) begin
    if (dut.key_evt_reg === 1'b1) last_evt_cyc = cyc;
    if (done) last_done_cyc = cyc;
    if (mon_en) begin
      if (digits !== prev_digits) begin
        if (dig_q.size() == 0) chk("digits_unexpected", 32'(digits), 32'(prev_digits));
        else                   chk("digits", 32'(digits), 32'(dig_q.pop_front()));
        $display("[TB] cycle %0d digits -> %07h", cyc, digits);
      end
      if (start && !prev_start) begin
        if (armed_q.size() == 0) begin
          chk("start_unexpected", 32'(start), 32'd0);
        end else begin
          mon_a = armed_q.pop_front();
          chk("armed_keyboard", 32'(keyboard), 32'(mon_a.kb));
          chk("armed_select", 32'(select), 32'(mon_a.sel));
          chk("start_latency", 32'(cyc - last_evt_cyc), 32'd8);
        end
        $display("[TB] cycle %0d start keyboard=%0d select=%0d", cyc, keyboard, select);
      end
      if (!start && prev_start) begin
        chk("release_keyboard", 32'(keyboard), 32'd0);
        chk("release_select", 32'(select), 32'd0);
        if (rel_q.size() == 0)          chk("release_unexpected", 32'(start), 32'd1);
        else if (rel_q.pop_front() == 1) chk("done_latency", 32'(cyc - last_done_cyc), 32'd1);
        $display("[TB] cycle %0d released", cyc);
      end
      if (err) begin
        if (err_q.size() == 0) chk("err_unexpected", 32'(err), 32'd0);
        else                   chk("err_latency", 32'(cyc - last_evt_cyc), 32'(err_q.pop_front()));
        if (prev_err) chk("err_width", 32'(err), 32'd0);
        $display("[TB] cycle %0d err pulse", cyc);
      end
    end
    prev_digits = digits;
    prev_start  = start;
    prev_err    = err;
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int code, input int frames);
    pressed[code] = 1'b1;
    tick(frames * FRAME);
    pressed = 16'd0;
    tick(3 * FRAME);
  endtask

  task automatic key(input int code);
    press(code, 3);
  endtask

  task automatic kd(input int code, input logic [27:0] exp);
    dig_q.push_back(exp);
    press(code, 3);
  endtask

  task automatic arm(input logic [23:0] kb, input logic [2:0] sel);
    armed_t a;
    a.kb  = kb;
    a.sel = sel;
    armed_q.push_back(a);
  endtask

  task automatic pulse_done();
    dig_q.push_back(28'd0);
    rel_q.push_back(1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"}, 32'(col), 32'hE);
    chk({tag, "_keyboard"}, 32'(keyboard), 32'd0);
    chk({tag, "_select"}, 32'(select), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_digits"}, 32'(digits), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [27:0] exp9;
    bit found;

    tick(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(2);
    mon_en = 1'b1;

    // # with nothing entered and no fuel -> err one cycle after the event
    err_q.push_back(1);
    key(KHASH);

    // B 5 0 0 0 0 #
    key(KB);
    kd(K5, 28'h0000005);
    kd(K0, 28'h0000050);
    kd(K0, 28'h0000500);
    kd(K0, 28'h0005000);
    kd(K0, 28'h0050000);
    arm(24'd50000, 3'd2);
    key(KHASH);
    chk("armed_digits", 32'(digits), 32'h0050000);
    chk("armed_start", 32'(start), 32'd1);
    pulse_done();

    // eight 9s, only seven kept; release with *
    exp9 = 28'd0;
    for (int i = 0; i < 7; i++) begin
      exp9 = {exp9[23:0], 4'h9};
      kd(K9, exp9);
    end
    key(K9);
    chk("seven_digits", 32'(digits), 32'h9999999);
    key(KA);
    arm(24'd9999999, 3'd1);
    key(KHASH);
    dig_q.push_back(28'd0);
    rel_q.push_back(0);
    key(KSTAR);

    // 1 2 3 D 4 C #
    kd(K1, 28'h0000001);
    kd(K2, 28'h0000012);
    kd(K3, 28'h0000123);
    kd(KD, 28'h0000012);
    kd(K4, 28'h0000124);
    key(KC);
`ifdef KEYPAD_MIN_AMOUNT_EN
    err_q.push_back(8);
    key(KHASH);
    dig_q.push_back(28'd0);
    key(KSTAR);
`else
    arm(24'd124, 3'd3);
    key(KHASH);
    pulse_done();
`endif

    // digits present but no fuel selected -> err, no start
    kd(K7, 28'h0000007);
    err_q.push_back(1);
    key(KHASH);
    chk("nosel_start", 32'(start), 32'd0);
    dig_q.push_back(28'd0);
    key(KSTAR);

    // multi-key frames and a one-frame tap produce no event
    pressed[K1] = 1'b1;
    pressed[K4] = 1'b1;
    tick(3 * FRAME);
    pressed = 16'd0;
    tick(3 * FRAME);
    pressed[K1] = 1'b1;
    pressed[K6] = 1'b1;
    tick(3 * FRAME);
    pressed = 16'd0;
    tick(3 * FRAME);
    press(K2, 1);
    chk("noevent_digits", 32'(digits), 32'd0);

    // long hold -> exactly one event
    dig_q.push_back(28'h0000007);
    press(K7, 10);
    chk("hold_digits", 32'(digits), 32'h0000007);
    dig_q.push_back(28'd0);
    key(KSTAR);

`ifdef KEYPAD_MIN_AMOUNT_EN
    // 5000 is below the minimum: err at N+8, entry retained; appending 0 then succeeds
    key(KA);
    kd(K5, 28'h0000005);
    kd(K0, 28'h0000050);
    kd(K0, 28'h0000500);
    kd(K0, 28'h0005000);
    err_q.push_back(8);
    key(KHASH);
    chk("min_start", 32'(start), 32'd0);
    chk("min_digits", 32'(digits), 32'h0005000);
    chk("min_select", 32'(select), 32'd1);
    kd(K0, 28'h0050000);
    arm(24'd50000, 3'd1);
    key(KHASH);
    pulse_done();
`endif

    // reset asserted mid-CONVERT
    kd(K1, 28'h0000001);
    key(KA);
    pressed[KHASH] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 * FRAME && !found; i++) begin
      @(negedge clk);
      if (dut.key_evt_reg === 1'b1 && dut.key_code_reg === 4'(KHASH)) found = 1'b1;
    end
    chk("hash_event_seen", 32'(found), 32'd1);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("midconv");
    pressed = 16'd0;
    tick(2);
    reset = 1'b1;
    tick(4 * FRAME);
    mon_en = 1'b1;
    chk("post_reset_start", 32'(start), 32'd0);
    chk("post_reset_keyboard", 32'(keyboard), 32'd0);
    tick(2);

    chk("dig_q_empty", 32'(dig_q.size()), 32'd0);
    chk("armed_q_empty", 32'(armed_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);
    chk("rel_q_empty", 32'(rel_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
